// File: rtl/add_pkg.sv
// Shared types for the multi-cycle adder/subtractor: operation select and FSM states.
package add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the top bit
// so the caller can derive signed overflow on the final chunk.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]       = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout  = c_s[CHUNK];
  assign c_msb = c_s[CHUNK-1];

endmodule

// File: rtl/multicycle_adder_sva.sv
// Port-level checker for multicycle_adder: every emitted result must match the
// full-width sum of the operands captured at accept; in_ready excludes busy.
module multicycle_adder_sva #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             in_valid,
  input logic             in_ready,
  input logic             op,
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  input logic             cin,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] sum,
  input logic             cout,
  input logic             ovf,
  input logic             busy
);

  logic [WIDTH-1:0] bb_s;
  logic [WIDTH:0]   full_s;
  logic             ovf_s;
  logic [WIDTH:0]   exp_r;
  logic             exp_ovf_r;
  logic             pending_r;

  assign bb_s   = op ? ~b : b;
  assign full_s = {1'b0, a} + {1'b0, bb_s} + {{WIDTH{1'b0}}, (op ? 1'b1 : cin)};
  assign ovf_s  = (a[WIDTH-1] == bb_s[WIDTH-1]) && (full_s[WIDTH-1] != a[WIDTH-1]);

  // Capture the expected result at accept time
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r     <= '0;
      exp_ovf_r <= 1'b0;
      pending_r <= 1'b0;
    end else if (in_valid && in_ready) begin
      exp_r     <= full_s;
      exp_ovf_r <= ovf_s;
      pending_r <= 1'b1;
    end else if (out_valid && out_ready) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  a_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && out_ready) |-> (pending_r && ({cout, sum} == exp_r) && (ovf == exp_ovf_r)));

  a_ready_idle: assert property (@(posedge clk) disable iff (rst) !(in_ready && busy));

endmodule

bind multicycle_adder multicycle_adder_sva #(.WIDTH(WIDTH)) u_sva (
  .clk       (clk),
  .rst       (rst),
  .in_valid  (in_valid),
  .in_ready  (in_ready),
  .op        (op),
  .a         (a),
  .b         (b),
  .cin       (cin),
  .out_valid (out_valid),
  .out_ready (out_ready),
  .sum       (sum),
  .cout      (cout),
  .ovf       (ovf),
  .busy      (busy)
);

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle LSB-first with a
// registered inter-chunk carry, valid/ready handshakes on input and output.
module multicycle_adder
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r, cout_r, ovf_r;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [31:0]      base_s;
  logic [CHUNK-1:0] s_chunk_s;
  logic             co_s, cm_s;

  assign base_s = 32'(cnt_r) * CHUNK;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_r[base_s +: CHUNK]),
    .b     (b_r[base_s +: CHUNK]),
    .cin   (carry_r),
    .s     (s_chunk_s),
    .cout  (co_s),
    .c_msb (cm_s)
  );

  // State register and registered handshake/status flags derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_s == S_DONE);
      busy_r      <= (state_s != S_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_s = S_BUSY;
        else          state_s = S_IDLE;
      end
      S_BUSY: begin
        if (cnt_r == LAST) state_s = S_DONE;
        else               state_s = S_BUSY;
      end
      S_DONE: begin
        if (out_ready) state_s = S_IDLE;
        else           state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and final flag generation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            cnt_r <= '0;
            // Subtraction is a + ~b + 1; the incoming cin is deliberately ignored
            if (op_e'(op) == OP_SUB) begin
              b_r     <= ~b;
              carry_r <= 1'b1;
            end else begin
              b_r     <= b;
              carry_r <= cin;
            end
          end
        end
        S_BUSY: begin
          sum_r[base_s +: CHUNK] <= s_chunk_s;
          carry_r                <= co_s;
          cnt_r                  <= cnt_r + 1'b1;
          if (cnt_r == LAST) begin
            cout_r <= co_s;
            ovf_r  <= cm_s ^ co_s;
          end
        end
        S_DONE:  cnt_r <= '0;
        default: cnt_r <= '0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench: WIDTH=8 with CHUNK=2 (dut0) and CHUNK=8 (dut1), directed
// and randomized operations against an integer-arithmetic reference model.
module tb_multicycle_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op  = 1'b0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic       cin = 1'b0;

  logic       in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic       in_ready0, out_valid0, cout0, ovf0, busy0;
  logic [7:0] sum0;
  logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic       in_ready1, out_valid1, cout1, ovf1, busy1;
  logic [7:0] sum1;

  int n_checks = 0;
  int n_pass   = 0;

  // Directed vectors, expected value packed as {ovf, cout, sum}
  logic [7:0] v_a   [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h80, 8'h05, 8'h05};
  logic [7:0] v_b   [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h07, 8'h07};
  logic       v_op  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       v_cin [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [9:0] v_exp [6] = '{10'h010, 10'h101, 10'h280, 10'h37F, 10'h0FE, 10'h0FE};

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  // Reference: unsigned sum gives sum/cout, signed sum gives overflow
  function automatic logic [9:0] model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                       input logic ci);
    int ux, uy, sx, sy, t, st;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == 1'b0) begin
      t  = ux + uy + int'(ci);
      st = sx + sy + int'(ci);
    end else begin
      t  = ux - uy + 256;
      st = sx - sy;
    end
    c = (t >= 256);
    v = (st > 127) || (st < -128);
    return {v, c, t[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch0(input logic o, input logic [7:0] x, input logic [7:0] y, input logic ci);
    op = o; a = x; b = y; cin = ci;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
  endtask

  task automatic launch1(input logic o, input logic [7:0] x, input logic [7:0] y, input logic ci);
    op = o; a = x; b = y; cin = ci;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
  endtask

  task automatic wait_done0(output int lat);
    int c = 0;
    while (out_valid0 !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    lat = (out_valid0 === 1'b1) ? c : -1;
  endtask

  task automatic wait_done1(output int lat);
    int c = 0;
    while (out_valid1 !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    lat = (out_valid1 === 1'b1) ? c : -1;
  endtask

  task automatic ack0();
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
  endtask

  task automatic ack1();
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready0, out_valid0, busy0, cout0, ovf0, sum0} !== {5'b10000, 8'h00})
      $display("FAIL reset0: got %b want %b", {in_ready0, out_valid0, busy0, cout0, ovf0, sum0},
               {5'b10000, 8'h00});
    else n_pass++;
    n_checks++;
    if ({in_ready1, out_valid1, busy1, cout1, ovf1, sum1} !== {5'b10000, 8'h00})
      $display("FAIL reset1: got %b want %b", {in_ready1, out_valid1, busy1, cout1, ovf1, sum1},
               {5'b10000, 8'h00});
    else n_pass++;
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 6; i++) begin
      launch0(v_op[i], v_a[i], v_b[i], v_cin[i]);
      a = 8'($urandom);
      b = 8'($urandom);
      wait_done0(lat);
      n_checks++;
      if (lat !== 4) $display("FAIL dir_latency[%0d]: got %0d want 4", i, lat);
      else n_pass++;
      n_checks++;
      if ({ovf0, cout0, sum0} !== v_exp[i])
        $display("FAIL dir_result[%0d]: got %h want %h", i, {ovf0, cout0, sum0}, v_exp[i]);
      else n_pass++;
      ack0();
      n_checks++;
      if ({out_valid0, in_ready0} !== 2'b01)
        $display("FAIL dir_release[%0d]: got %b want 01", i, {out_valid0, in_ready0});
      else n_pass++;
    end
  endtask

  task automatic test_nchunk1();
    int lat;
    for (int i = 0; i < 4; i++) begin
      launch1(v_op[i], v_a[i], v_b[i], v_cin[i]);
      wait_done1(lat);
      n_checks++;
      if (lat !== 1) $display("FAIL n1_latency[%0d]: got %0d want 1", i, lat);
      else n_pass++;
      n_checks++;
      if ({ovf1, cout1, sum1} !== v_exp[i])
        $display("FAIL n1_result[%0d]: got %h want %h", i, {ovf1, cout1, sum1}, v_exp[i]);
      else n_pass++;
      ack1();
    end
  endtask

  task automatic test_random();
    int lat;
    logic [9:0] exp;
    logic o, ci;
    logic [7:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 1'($urandom); ci = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      exp = model(o, x, y, ci);
      if (i % 3 == 2) begin
        launch1(o, x, y, ci);
        wait_done1(lat);
        n_checks++;
        if (lat !== 1 || {ovf1, cout1, sum1} !== exp)
          $display("FAIL rnd1[%0d]: got lat %0d res %h want lat 1 res %h", i, lat,
                   {ovf1, cout1, sum1}, exp);
        else n_pass++;
        ack1();
      end else begin
        launch0(o, x, y, ci);
        op = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        wait_done0(lat);
        for (int d = 0; d < int'($urandom_range(3, 0)); d++) tick();
        n_checks++;
        if (lat !== 4 || {ovf0, cout0, sum0} !== exp)
          $display("FAIL rnd0[%0d]: got lat %0d res %h want lat 4 res %h", i, lat,
                   {ovf0, cout0, sum0}, exp);
        else n_pass++;
        ack0();
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [9:0] exp1, exp2;
    logic [7:0] x2, y2;
    exp1 = model(1'b0, 8'h3C, 8'hA5, 1'b1);
    op = 1'b0; a = 8'h3C; b = 8'hA5; cin = 1'b1;
    in_valid0 = 1'b1;
    tick();
    x2 = 8'($urandom); y2 = 8'($urandom);
    op = 1'b1; a = x2; b = y2;
    exp2 = model(1'b1, x2, y2, 1'b1);
    wait_done0(lat);
    n_checks++;
    if (lat !== 4) $display("FAIL b2b_latency: got %0d want 4", lat);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out_valid0, in_ready0, ovf0, cout0, sum0} !== {2'b10, exp1})
        $display("FAIL stall[%0d]: got %h want %h", i, {out_valid0, in_ready0, ovf0, cout0, sum0},
                 {2'b10, exp1});
      else n_pass++;
    end
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
    n_checks++;
    if ({out_valid0, in_ready0, busy0} !== 3'b010)
      $display("FAIL b2b_idle: got %b want 010", {out_valid0, in_ready0, busy0});
    else n_pass++;
    tick();
    in_valid0 = 1'b0;
    n_checks++;
    if ({in_ready0, busy0} !== 2'b01)
      $display("FAIL b2b_accept2: got %b want 01", {in_ready0, busy0});
    else n_pass++;
    wait_done0(lat);
    n_checks++;
    if (lat !== 4 || {ovf0, cout0, sum0} !== exp2)
      $display("FAIL b2b_second: got lat %0d res %h want lat 4 res %h", lat, {ovf0, cout0, sum0}, exp2);
    else n_pass++;
    ack0();
  endtask

  task automatic test_abort();
    int lat, seen;
    launch0(1'b0, 8'h5A, 8'h33, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out_valid0, in_ready0, busy0, sum0, cout0, ovf0} !== {3'b010, 8'h00, 2'b00})
      $display("FAIL abort_state: got %h want %h", {out_valid0, in_ready0, busy0, sum0, cout0, ovf0},
               {3'b010, 8'h00, 2'b00});
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid0 === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    else n_pass++;
    launch0(1'b1, 8'h10, 8'h20, 1'b0);
    wait_done0(lat);
    n_checks++;
    if (lat !== 4 || {ovf0, cout0, sum0} !== model(1'b1, 8'h10, 8'h20, 1'b0))
      $display("FAIL abort_recover: got lat %0d res %h want lat 4 res %h", lat, {ovf0, cout0, sum0},
               model(1'b1, 8'h10, 8'h20, 1'b0));
    else n_pass++;
    ack0();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_nchunk1();
    test_random();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
